// File: rtl/dma_priority_arbiter_pkg.sv
// Shared types and constants for the DMA channel arbiter.
// Holds the FSM state encoding, the channel index type and the rotation helper.
package dma_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = $clog2(NUM_CH);

    typedef logic [CH_W-1:0] chan_t;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        REQ     = 4'b0010,
        GRANT   = 4'b0100,
        RELEASE = 4'b1000
    } arbState_t;

    localparam logic [NUM_CH*CH_W-1:0] PRIORITY_ORDER_RESET = 8'b11_10_01_00;

    // Serviced channel c drops to slot3, c+1 becomes slot0.
    function automatic logic [NUM_CH*CH_W-1:0] rotate_order(input chan_t c);
        chan_t s0;
        chan_t s1;
        chan_t s2;
        s0 = chan_t'(c + chan_t'(1));
        s1 = chan_t'(c + chan_t'(2));
        s2 = chan_t'(c + chan_t'(3));
        return {c, s2, s1, s0};
    endfunction

endpackage

// File: rtl/dma_priority_resolver.sv
// Combinational priority resolver for the DMA arbiter.
// Picks the first slot (slot0 first) whose channel has a qualified request.
module dma_priority_resolver
    import dma_pkg::*;
(
    input  logic [NUM_CH-1:0]      req,
    input  logic [NUM_CH*CH_W-1:0] priorityOrder,
    output logic                   winnerValid,
    output chan_t                  winnerCh
);

    // Scan from the lowest-priority slot up so slot0 overrides last.
    always_comb begin
        winnerValid = 1'b0;
        winnerCh    = '0;
        for (int s = NUM_CH - 1; s >= 0; s--) begin
            if (req[priorityOrder[s*CH_W +: CH_W]]) begin
                winnerValid = 1'b1;
                winnerCh    = priorityOrder[s*CH_W +: CH_W];
            end
        end
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// 8237-style DMA request arbiter and HRQ/HLDA bus-hold sequencer.
// Rotating priority is built only when DMA_ROTATING_PRIORITY_EN is defined.
module dma_priority_arbiter
    import dma_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [NUM_CH-1:0]      DREQ,
    input  logic [NUM_CH-1:0]      maskReg,
    input  logic                   priorityType,
    input  logic                   controllerDisable,
    input  logic                   HLDA,
    input  logic                   svcDone,
    output logic                   HRQ,
    output logic [NUM_CH-1:0]      DACK,
    output logic                   grantValid,
    output chan_t                  grantChannel,
    output logic [NUM_CH*CH_W-1:0] priorityOrder,
    output logic                   busy
);

    arbState_t         state_q, state_d;
    logic              hrq_q, hrq_d;
    logic [NUM_CH-1:0] dack_q, dack_d;
    logic              grant_valid_q, grant_valid_d;
    chan_t             grant_ch_q, grant_ch_d;

    logic [NUM_CH-1:0] req;
    logic              win_valid;
    chan_t             win_ch;

    assign req = DREQ & ~maskReg & {NUM_CH{~controllerDisable}};

    dma_priority_resolver u_resolver (
        .req           (req),
        .priorityOrder (priorityOrder),
        .winnerValid   (win_valid),
        .winnerCh      (win_ch)
    );

`ifdef DMA_ROTATING_PRIORITY_EN
    logic [NUM_CH*CH_W-1:0] order_q, order_d;

    // Fixed mode pins the order; rotate only on a completed service.
    always_comb begin
        order_d = order_q;
        if (!priorityType) begin
            order_d = PRIORITY_ORDER_RESET;
        end else if (state_q == GRANT && svcDone) begin
            order_d = rotate_order(grant_ch_q);
        end
    end

    // Priority order register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            order_q <= PRIORITY_ORDER_RESET;
        end else begin
            order_q <= order_d;
        end
    end

    assign priorityOrder = order_q;
`else
    logic unused_priority_type;

    assign unused_priority_type = priorityType;
    assign priorityOrder        = PRIORITY_ORDER_RESET;
`endif

    // Next-state and registered-output logic of the hold sequencer.
    always_comb begin
        state_d       = state_q;
        hrq_d         = hrq_q;
        dack_d        = dack_q;
        grant_valid_d = 1'b0;
        grant_ch_d    = grant_ch_q;
        unique case (1'b1)
            state_q[0]: begin
                if (|req) begin
                    hrq_d   = 1'b1;
                    state_d = REQ;
                end
            end
            state_q[1]: begin
                if (HLDA && win_valid) begin
                    grant_ch_d    = win_ch;
                    dack_d        = NUM_CH'(1) << win_ch;
                    grant_valid_d = 1'b1;
                    state_d       = GRANT;
                end else if (HLDA) begin
                    hrq_d   = 1'b0;
                    state_d = RELEASE;
                end else if (!(|req)) begin
                    hrq_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            state_q[2]: begin
                if (svcDone) begin
                    dack_d  = '0;
                    hrq_d   = 1'b0;
                    state_d = RELEASE;
                end else if (!HLDA) begin
                    dack_d  = '0;
                    hrq_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            state_q[3]: begin
                if (!HLDA) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                hrq_d   = 1'b0;
                dack_d  = '0;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            hrq_q         <= 1'b0;
            dack_q        <= '0;
            grant_valid_q <= 1'b0;
            grant_ch_q    <= '0;
        end else begin
            state_q       <= state_d;
            hrq_q         <= hrq_d;
            dack_q        <= dack_d;
            grant_valid_q <= grant_valid_d;
            grant_ch_q    <= grant_ch_d;
        end
    end

    assign HRQ          = hrq_q;
    assign DACK         = dack_q;
    assign grantValid   = grant_valid_q;
    assign grantChannel = grant_ch_q;
    assign busy         = (state_q == GRANT);

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed vector bench for dma_priority_arbiter.
// Rotation expectations follow DMA_ROTATING_PRIORITY_EN.
module tb_dma_priority_arbiter;

    typedef struct {
        logic       rst;
        logic [3:0] dreq;
        logic [3:0] mask;
        logic       pt;
        logic       cd;
        logic       hlda;
        logic       svc;
        logic       hrq;
        logic [3:0] dack;
        logic       gv;
        logic [1:0] gch;
        logic       busy;
        logic [7:0] ord;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] DREQ = '0;
    logic [3:0] maskReg = '0;
    logic       priorityType = 1'b0;
    logic       controllerDisable = 1'b0;
    logic       HLDA = 1'b0;
    logic       svcDone = 1'b0;
    logic       HRQ;
    logic [3:0] DACK;
    logic       grantValid;
    logic [1:0] grantChannel;
    logic [7:0] priorityOrder;
    logic       busy;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] ORD0 = 8'hE4;
`ifdef DMA_ROTATING_PRIORITY_EN
    localparam logic [7:0] ORD1 = 8'h39;
    localparam logic [7:0] ORD2 = 8'h4E;
    localparam logic [1:0] G2   = 2'd1;
    localparam logic [1:0] G3   = 2'd2;
`else
    localparam logic [7:0] ORD1 = 8'hE4;
    localparam logic [7:0] ORD2 = 8'hE4;
    localparam logic [1:0] G2   = 2'd0;
    localparam logic [1:0] G3   = 2'd0;
`endif

    always #5 CLK = ~CLK;

    dma_priority_arbiter dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .DREQ              (DREQ),
        .maskReg           (maskReg),
        .priorityType      (priorityType),
        .controllerDisable (controllerDisable),
        .HLDA              (HLDA),
        .svcDone           (svcDone),
        .HRQ               (HRQ),
        .DACK              (DACK),
        .grantValid        (grantValid),
        .grantChannel      (grantChannel),
        .priorityOrder     (priorityOrder),
        .busy              (busy)
    );

    function automatic vec_t mk(
        input logic rst, input logic [3:0] dreq, input logic [3:0] mask,
        input logic pt, input logic cd, input logic hlda, input logic svc,
        input logic hrq, input logic [3:0] dack, input logic gv,
        input logic [1:0] gch, input logic bsy, input logic [7:0] ord);
        vec_t v;
        v.rst = rst;   v.dreq = dreq; v.mask = mask; v.pt = pt;
        v.cd = cd;     v.hlda = hlda; v.svc = svc;   v.hrq = hrq;
        v.dack = dack; v.gv = gv;     v.gch = gch;   v.busy = bsy;
        v.ord = ord;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [16:0] got;
        logic [16:0] exp;
        @(negedge CLK);
        RESET             = v.rst;
        DREQ              = v.dreq;
        maskReg           = v.mask;
        priorityType      = v.pt;
        controllerDisable = v.cd;
        HLDA              = v.hlda;
        svcDone           = v.svc;
        @(posedge CLK);
        #1;
        got = {HRQ, DACK, grantValid, grantChannel, busy, priorityOrder};
        exp = {v.hrq, v.dack, v.gv, v.gch, v.busy, v.ord};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got hrq=%b dack=%b gv=%b gch=%0d busy=%b ord=%h, expected hrq=%b dack=%b gv=%b gch=%0d busy=%b ord=%h",
                     name, HRQ, DACK, grantValid, grantChannel, busy, priorityOrder,
                     v.hrq, v.dack, v.gv, v.gch, v.busy, v.ord);
        end
    endtask

    vec_t tbl[$];

    initial begin
        //            rst dreq     mask     pt cd hl sv  hrq dack     gv gch busy ord
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, ORD0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, ORD0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 0, 1, 0, 1, 4'b0001, 1, 0, 1, ORD0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 0, 1, 0, 1, 4'b0001, 0, 0, 1, ORD0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 0, 1, 1, 0, 4'b0000, 0, 0, 0, ORD0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, ORD0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, ORD0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, ORD0));
        tbl.push_back(mk(0, 4'b0101, 4'b0001, 0, 0, 1, 0, 1, 4'b0100, 1, 2, 1, ORD0));
        tbl.push_back(mk(0, 4'b0101, 4'b0001, 0, 0, 1, 1, 0, 4'b0000, 0, 2, 0, ORD0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 2, 0, ORD0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 0, 2, 0, ORD0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 0, 2, 0, ORD0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 2, 0, ORD0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 2, 0, ORD0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 2, 0, ORD0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 2, 0, ORD0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 1, 0, 0, 4'b0000, 0, 2, 0, ORD0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 0, 1, 0, 0, 4'b0000, 0, 2, 0, ORD0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 2, 0, ORD0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 2, 0, ORD0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 0, 1, 0, 1, 4'b1000, 1, 3, 1, ORD0));
        tbl.push_back(mk(0, 4'b0001, 4'b1000, 0, 0, 1, 0, 1, 4'b1000, 0, 3, 1, ORD0));
        tbl.push_back(mk(0, 4'b0001, 4'b1000, 0, 0, 0, 1, 0, 4'b0000, 0, 3, 0, ORD0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 3, 0, ORD0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Rotating mode with all requests held: ch0 then the next in order.
        apply(mk(0, 4'b1111, 4'b0000, 1, 0, 0, 0, 1, 4'b0000, 0, 3, 0, ORD0), "rot_req");
        apply(mk(0, 4'b1111, 4'b0000, 1, 0, 1, 0, 1, 4'b0001, 1, 0, 1, ORD0), "rot_grant0");
        apply(mk(0, 4'b1111, 4'b0000, 1, 0, 1, 1, 0, 4'b0000, 0, 0, 0, ORD1), "rot_done0");
        apply(mk(0, 4'b1111, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, ORD1), "rot_idle0");
        apply(mk(0, 4'b1111, 4'b0000, 1, 0, 0, 0, 1, 4'b0000, 0, 0, 0, ORD1), "rot_req1");
        apply(mk(0, 4'b1111, 4'b0000, 1, 0, 1, 0, 1, 4'(1) << G2, 1, G2, 1, ORD1), "rot_grant1");
        apply(mk(0, 4'b1111, 4'b0000, 1, 0, 1, 1, 0, 4'b0000, 0, G2, 0, ORD2), "rot_done1");
        apply(mk(0, 4'b1111, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0, G2, 0, ORD2), "rot_idle1");

        // Reset in the middle of a grant.
        apply(mk(0, 4'b1111, 4'b0000, 1, 0, 0, 0, 1, 4'b0000, 0, G2, 0, ORD2), "rst_req");
        apply(mk(0, 4'b1111, 4'b0000, 1, 0, 1, 0, 1, 4'(1) << G3, 1, G3, 1, ORD2), "rst_grant");
        apply(mk(0, 4'b1111, 4'b0000, 1, 0, 1, 0, 1, 4'(1) << G3, 0, G3, 1, ORD2), "rst_hold");
        apply(mk(1, 4'b1111, 4'b0000, 1, 0, 1, 0, 0, 4'b0000, 0, 0, 0, ORD0), "rst_mid");
        apply(mk(0, 4'b0000, 4'b0000, 1, 0, 1, 0, 0, 4'b0000, 0, 0, 0, ORD0), "rst_after");

        // HLDA drops during a grant on ch2: abort without rotation.
        apply(mk(0, 4'b0100, 4'b0000, 1, 0, 0, 0, 1, 4'b0000, 0, 0, 0, ORD0), "abort_req");
        apply(mk(0, 4'b0100, 4'b0000, 1, 0, 1, 0, 1, 4'b0100, 1, 2, 1, ORD0), "abort_grant");
        apply(mk(0, 4'b0100, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0, 2, 0, ORD0), "abort_drop");
        apply(mk(0, 4'b0100, 4'b0000, 1, 0, 0, 0, 1, 4'b0000, 0, 2, 0, ORD0), "abort_rereq");
        apply(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 2, 0, ORD0), "abort_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Channel request arbiter and bus-hold sequencer for the 4-channel 8237-style DMA controller.
- Qualifies DREQ[3:0] against the mask and command bits, and runs the HRQ/HLDA handshake with the CPU.
- Selects one channel by fixed or rotating priority, drives DACK, and hands the granted channel to timing control.
- Holds the grant until timing control reports end of service.

Parameters:
- NUM_CH, 4, number of DMA channels; only 4 is supported.
- CH_W, 2, channel index width; equals $clog2(NUM_CH).

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- DREQ  input  4  channel DMA requests, active-high.
- maskReg  input  4  per-channel request mask; 1 blocks the channel.
- priorityType  input  1  command register bit; 0 = fixed, 1 = rotating.
- controllerDisable  input  1  command register bit; 1 blocks all requests.
- HLDA  input  1  hold acknowledge from the CPU.
- svcDone  input  1  one-cycle pulse from timing control at end of service (TC, EOP or single transfer done).
- HRQ  output  1  hold request to the CPU.
- DACK  output  4  one-hot DMA acknowledge, active-high.
- grantValid  output  1  one-cycle pulse when a grant is issued.
- grantChannel  output  2  index of the granted channel; valid while busy.
- priorityOrder  output  8  four 2-bit slots; slot0 = bits[1:0] = highest priority.
- busy  output  1  high in the GRANT state.

Behaviour:
- Reset (RESET=1 at a clock edge):
  - State goes to IDLE.
  - HRQ=0, DACK=4'b0000, grantValid=0, grantChannel=2'b00, busy=0.
  - priorityOrder=8'b11_10_01_00.
  - Reset wins over every other event, including reset in the middle of a grant.
- Qualified request: req[i] = DREQ[i] & ~maskReg[i] & ~controllerDisable.
- Resolver: the winner is the first slot, scanning slot0 to slot3, whose channel has req set. There is no winner if req==0.
- IDLE:
  - If |req, register HRQ=1 next cycle and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - HRQ is held at 1.
  - If req==0 while HLDA=0: clear HRQ next cycle and go to IDLE.
  - If HLDA=1 and |req: latch the winner into grantChannel, set DACK one-hot, pulse grantValid, go to GRANT. All of these are registered, so visible the cycle after HLDA is sampled.
  - If HLDA=1 and req==0: clear HRQ and go to RELEASE.
- GRANT:
  - DACK, grantChannel and HRQ are held; busy=1.
  - The grant is frozen: changes to DREQ, maskReg or priorityType are ignored until it ends.
  - On svcDone: clear DACK and HRQ, and go to RELEASE.
  - On svcDone with priorityType=1: rotate priorityOrder so the serviced channel c takes slot3 and (c+1) mod 4 takes slot0.
  - If HLDA drops before svcDone (abort): clear DACK and HRQ, go to IDLE, and do not rotate.
- RELEASE:
  - Wait for HLDA=0, then go to IDLE.
  - No new HRQ is raised while HLDA is still 1.
- Fixed mode (priorityType=0): priorityOrder is forced to 8'b11_10_01_00 every cycle.
- Latency:
  - DREQ to HRQ is 1 cycle.
  - HLDA to DACK is 1 cycle.
  - svcDone to DACK=0 is 1 cycle.
  - Minimum spacing from one grant to the next is 4 cycles.
- Simultaneous svcDone and HLDA fall in GRANT: treat as a normal completion (rotate if enabled), then pass through RELEASE to IDLE.
- DACK is never more than one-hot. DACK!=0 only when busy=1.

Optional Feature:
- Macro: DMA_ROTATING_PRIORITY_EN.
- Defined: rotating priority behaves as described above.
- Undefined: the priorityType input is ignored, priorityOrder is a constant 8'b11_10_01_00, and no rotation logic is synthesised.

Decomposition:
- Shared package dma_pkg contains:
  - arbState_t enum {IDLE, REQ, GRANT, RELEASE}, one-hot encoded;
  - PRIORITY_ORDER_RESET = 8'b11_10_01_00;
  - the CH_W typedef chan_t.
- Sub-module dma_priority_resolver: combinational, takes (req[3:0], priorityOrder) and produces (winnerValid, winnerCh).

Test Plan:
- DREQ=4'b1111, mask=0, fixed: HRQ rises after 1 cycle. After HLDA=1, DACK=4'b0001 and grantValid pulses once.
- Rotating mode, DREQ=4'b1111 held:
  - ch0 serviced, then svcDone; priorityOrder becomes 8'b00_11_10_01.
  - Next grant is DACK=4'b0010.
- DREQ=4'b0101, maskReg=4'b0001: DACK=4'b0100. With controllerDisable=1, HRQ stays 0.
- DREQ drops to 4'b0000 in REQ with HLDA=0: HRQ returns to 0 and state goes to IDLE.
- HLDA falls during GRANT on ch2: DACK goes to 4'b0000 next cycle and priorityOrder is unchanged.
- RESET asserted mid-GRANT: the next cycle shows HRQ=0, DACK=0, and priorityOrder=8'b11_10_01_00.
